// File: rtl/seq_detect_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_pkg
//  Description : Shared types and defaults for the programmable serial
//                pattern detector.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_detect_pkg;

    // Default maximum pattern length in bits.
    localparam int C_DEFAULT_MAX_W = 8;

    // Detector FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HUNT = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_detect_param_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : WIDTH-bit saturating up-counter with synchronous clear
//                (clear wins over increment) and a saturation flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count,
    output logic             o_sat
);

    logic [WIDTH-1:0] r_count;

    // Count increments, holding at all-ones; clear overrides an increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !o_sat) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_sat   = (r_count == '1);

endmodule
`default_nettype wire

// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_param
//  Description : Runtime-programmable serial bit-pattern detector. Pattern
//                length 1..MAX_W, overlap / non-overlap matching, qualified
//                input strobe, registered match pulse and saturating count.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter  int MAX_W = C_DEFAULT_MAX_W,
    parameter  int CNT_W = 16,
    localparam int LEN_W = $clog2(MAX_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             din,
    input  logic             din_valid,
    input  logic             cfg_load,
    input  logic [MAX_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             dout,
    output logic [CNT_W-1:0] match_count,
    output logic             cnt_sat,
    output logic             cfg_err
);

    logic [MAX_W-1:0] r_pattern;
    logic [LEN_W-1:0] r_len;
    logic             r_overlap;
    logic [MAX_W-1:0] r_window;
    logic [LEN_W-1:0] r_fill;
    state_t           r_state;

    logic             w_cfg_ok;
    logic             w_sample;
    logic [MAX_W-1:0] w_window_nxt;
    logic [LEN_W-1:0] w_fill_inc;
    logic [MAX_W-1:0] w_mask;
    logic             w_hit;
    logic             w_match;

    // Window shift, length mask, compare and match qualification.
    always_comb begin
        w_cfg_ok     = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_W));
        // A cfg_load in the same cycle discards the incoming bit.
        w_sample     = din_valid && !cfg_load && enable;
        w_window_nxt = {r_window[MAX_W-2:0], din};
        w_fill_inc   = r_fill + LEN_W'(1);
        for (int i = 0; i < MAX_W; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
        w_hit   = (((w_window_nxt ^ r_pattern) & w_mask) == '0);
        w_match = 1'b0;
        if (w_sample) begin
            case (r_state)
                FILL:    w_match = w_hit && (w_fill_inc == r_len);
                HUNT:    w_match = w_hit;
                default: w_match = 1'b0;
            endcase
        end
    end

    // Configuration, history window and detector FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pattern <= '0;
            r_len     <= '0;
            r_overlap <= 1'b0;
            r_window  <= '0;
            r_fill    <= '0;
            r_state   <= IDLE;
            dout      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            dout    <= w_match;
            cfg_err <= cfg_load && !w_cfg_ok;
            if (cfg_load && w_cfg_ok) begin
                r_pattern <= cfg_pattern;
                r_len     <= cfg_len;
                r_overlap <= cfg_overlap;
                r_window  <= '0;
                r_fill    <= '0;
                r_state   <= enable ? FILL : IDLE;
            end else if (!enable) begin
                r_window <= '0;
                r_fill   <= '0;
                r_state  <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (r_len != '0) begin
                            r_state <= FILL;
                        end
                    end
                    FILL: begin
                        if (w_sample) begin
                            r_window <= w_window_nxt;
                            if (w_fill_inc == r_len) begin
                                // A non-overlapping match on the last fill bit restarts the fill.
                                if (w_match && !r_overlap) begin
                                    r_fill <= '0;
                                end else begin
                                    r_fill  <= w_fill_inc;
                                    r_state <= HUNT;
                                end
                            end else begin
                                r_fill <= w_fill_inc;
                            end
                        end
                    end
                    HUNT: begin
                        if (w_sample) begin
                            r_window <= w_window_nxt;
                            if (w_match && !r_overlap) begin
                                r_fill  <= '0;
                                r_state <= FILL;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_inc   (w_match),
        .i_clr   (cnt_clr),
        .o_count (match_count),
        .o_sat   (cnt_sat)
    );

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detect_param
//  Description : Self-checking bench for seq_detect_param. A queue-based
//                reference model tracks the bits seen since the last restart
//                and flags a match when the newest len bits equal the pattern.
//                A second instance with a 2-bit counter exercises saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_param;

    localparam int C_MAX_W = 8;
    localparam int C_LEN_W = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable, din, din_valid, cfg_load, cfg_overlap, cnt_clr;
    logic [C_MAX_W-1:0] cfg_pattern;
    logic [C_LEN_W-1:0] cfg_len;
    logic               dout, cnt_sat, cfg_err;
    logic [15:0]        match_count;
    logic               dout2, cnt_sat2, cfg_err2;
    logic [1:0]         match_count2;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ov;
    bit         m_armed;
    bit         hist[$];
    int         cnt16, cnt2;

    always #5 clk = ~clk;

    seq_detect_param #(.MAX_W(C_MAX_W), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .din(din), .din_valid(din_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .dout(dout),
        .match_count(match_count), .cnt_sat(cnt_sat), .cfg_err(cfg_err)
    );

    seq_detect_param #(.MAX_W(C_MAX_W), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .enable(enable), .din(din), .din_valid(din_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .dout(dout2),
        .match_count(match_count2), .cnt_sat(cnt_sat2), .cfg_err(cfg_err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_hit();
        if (hist.size() < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            if (hist[hist.size() - 1 - k] != m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_pat = '0; m_len = 0; m_ov = 0; m_armed = 0;
        hist.delete();
        cnt16 = 0; cnt2 = 0;
    endtask

    // One clock cycle: drive inputs, predict, then check after the edge.
    task automatic step(input bit en, input bit d, input bit v, input bit ld,
                        input logic [7:0] pat, input logic [3:0] len,
                        input bit ov, input bit clr);
        bit e_dout, e_err;
        @(negedge clk);
        enable = en; din = d; din_valid = v; cfg_load = ld;
        cfg_pattern = pat; cfg_len = len; cfg_overlap = ov; cnt_clr = clr;
        e_dout = 1'b0;
        e_err  = ld && !(len >= 1 && len <= C_MAX_W);
        if (ld && !e_err) begin
            m_pat = pat; m_len = int'(len); m_ov = ov; m_armed = en;
            hist.delete();
        end else if (!en) begin
            hist.delete();
            m_armed = 1'b0;
        end else if (!m_armed) begin
            if (m_len != 0) m_armed = 1'b1;
        end else if (v && !ld) begin
            hist.push_back(d);
            if (hist.size() > C_MAX_W) void'(hist.pop_front());
            if (model_hit()) begin
                e_dout = 1'b1;
                if (!m_ov) hist.delete();
            end
        end
        if (clr) begin
            cnt16 = 0; cnt2 = 0;
        end else if (e_dout) begin
            if (cnt16 < 65535) cnt16++;
            if (cnt2 < 3) cnt2++;
        end
        @(posedge clk);
        #1;
        chk("dout", dout, e_dout);
        chk("cfg_err", cfg_err, e_err);
        chk("match_count", match_count, cnt16);
        chk("cnt_sat", cnt_sat, cnt16 == 65535);
        chk("match_count2", match_count2, cnt2);
        chk("cnt_sat2", cnt_sat2, cnt2 == 3);
    endtask

    task automatic bit_in(input bit d);
        step(1'b1, d, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic gap();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input bit ov);
        step(1'b1, 1'b0, 1'b0, 1'b1, pat, len, ov, 1'b0);
    endtask

    task automatic clear_cnt();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0] a5;
        logic [4:0] s1;
        logic [7:0] s2;
        reset = 1'b1;
        enable = 0; din = 0; din_valid = 0; cfg_load = 0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0; cnt_clr = 0;
        model_reset();
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_count", match_count, 0);
        chk("rst_sat", cnt_sat, 0);
        chk("rst_err", cfg_err, 0);
        #16 reset = 1'b0;

        // Unconfigured detector never matches.
        for (int i = 0; i < 4; i++) bit_in(1'b1);

        // Overlapping 101.
        load(8'b101, 4'd3, 1'b1);
        s1 = 5'b10101;
        for (int i = 4; i >= 0; i--) bit_in(s1[i]);

        // Non-overlapping 101.
        clear_cnt();
        load(8'b101, 4'd3, 1'b0);
        s2 = 8'b10101101;
        for (int i = 7; i >= 0; i--) bit_in(s2[i]);

        // Full-width A5 with random gaps.
        clear_cnt();
        load(8'hA5, 4'd8, 1'b0);
        a5 = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            while ($urandom_range(0, 2) == 0) gap();
            bit_in(a5[i]);
        end
        gap();

        // Rejected loads keep configuration and history.
        load(8'b101, 4'd3, 1'b1);
        bit_in(1'b1);
        bit_in(1'b0);
        load(8'h00, 4'd0, 1'b0);
        load(8'hFF, 4'd9, 1'b0);
        bit_in(1'b1);
        bit_in(1'b0);
        bit_in(1'b1);

        // Saturation on the 2-bit instance, then clear beating a match.
        load(8'h01, 4'd1, 1'b1);
        clear_cnt();
        for (int i = 0; i < 5; i++) bit_in(1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
        bit_in(1'b0);
        bit_in(1'b1);

        // Enable drop clears history.
        load(8'b11, 4'd2, 1'b1);
        bit_in(1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        gap();
        bit_in(1'b1);
        bit_in(1'b1);

        // Asynchronous reset between edges, right after a match.
        bit_in(1'b1);
        #2 reset = 1'b1;
        #1;
        chk("async_dout", dout, 0);
        chk("async_count", match_count, 0);
        chk("async_count2", match_count2, 0);
        chk("async_sat2", cnt_sat2, 0);
        model_reset();
        #10 reset = 1'b0;
        for (int i = 0; i < 4; i++) bit_in(1'b1);
        load(8'h01, 4'd1, 1'b0);
        bit_in(1'b1);
        bit_in(1'b0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bit         en, ld;
            logic [3:0] len;
            en  = ($urandom_range(0, 59) != 0);
            ld  = ($urandom_range(0, 39) == 0);
            len = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'($urandom_range(1, 4));
            step(en, 1'($urandom), ($urandom_range(0, 9) < 7), ld,
                 8'($urandom), len, 1'($urandom), ($urandom_range(0, 49) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
